// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_fifo : edge-triggered capture of received words into a show-ahead
//                circular FIFO with a sticky overflow flag.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH_LOG2  = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [WORD_LENGTH-1:0] Data_In,
  input  logic                   Flag_Rx,
  input  logic                   Read_En,
  input  logic                   Clear_Overflow,
  output logic [WORD_LENGTH-1:0] Data_Out,
  output logic                   Empty,
  output logic                   Full,
  output logic [DEPTH_LOG2:0]    Count,
  output logic                   Overflow
);

  localparam int                C_DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WORD_LENGTH-1:0] mem_q [C_DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   flag_q;

  logic w_wr_stb;
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_ovf_set;

  assign Empty = (count_q == '0);
  assign Full  = (count_q == C_FULL_COUNT);

  // A full FIFO still accepts the write when a pop frees the head slot on the same edge.
  assign w_wr_stb  = Flag_Rx & ~flag_q;
  assign w_rd_fire = Read_En & ~Empty;
  assign w_wr_fire = w_wr_stb & (~Full | w_rd_fire);
  assign w_ovf_set = w_wr_stb & Full & ~Read_En;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (w_wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_wr_fire, w_rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (Clear_Overflow) ovf_d = 1'b0;
    if (w_ovf_set)      ovf_d = 1'b1;
  end

  // flag_q resets high so a level already present at reset release is not a new word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      flag_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      flag_q   <= Flag_Rx;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && w_wr_fire) mem_q[wr_ptr_q] <= Data_In;
  end

  assign Data_Out = Empty ? '0 : mem_q[rd_ptr_q];
  assign Count    = count_q;
  assign Overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo : scoreboard bench for uart_rx_fifo.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Data_In = '0;
  logic       Flag_Rx = 1'b0;
  logic       Read_En = 1'b0;
  logic       Clear_Overflow = 1'b0;
  logic [7:0] Data_Out;
  logic       Empty;
  logic       Full;
  logic [3:0] Count;
  logic       Overflow;

  logic [7:0] sb[$];
  int         m_count;
  int         checks = 0;
  int         failures = 0;

  uart_rx_fifo #(.WORD_LENGTH(8), .DEPTH_LOG2(3)) dut (
    .Clk(Clk), .Reset(Reset), .Data_In(Data_In), .Flag_Rx(Flag_Rx),
    .Read_En(Read_En), .Clear_Overflow(Clear_Overflow), .Data_Out(Data_Out),
    .Empty(Empty), .Full(Full), .Count(Count), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Flag_Rx = 1'b0; Read_En = 1'b0; Clear_Overflow = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    sb.delete();
    m_count = 0;
  endtask

  task automatic push_word(input logic [7:0] b);
    Data_In = b; Flag_Rx = 1'b1;
    tick();
    Flag_Rx = 1'b0;
    tick();
    if (m_count < 8) begin
      sb.push_back(b);
      m_count++;
    end
  endtask

  task automatic pop_word(output logic [7:0] head);
    head = Data_Out;
    Read_En = 1'b1;
    tick();
    Read_En = 1'b0;
    if (m_count > 0) m_count--;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", Empty); end
    checks++; if (Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", Full); end
    checks++; if (Count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
    checks++; if (Data_Out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", Data_Out); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
  endtask

  task automatic test_single_pulse();
    logic [7:0] got, exp;
    do_reset();
    Data_In = 8'hA5; Flag_Rx = 1'b1;
    sb.push_back(8'hA5); m_count = 1;
    repeat (5) tick();
    Flag_Rx = 1'b0;
    tick();
    checks++; if (Count !== 4'd1) begin failures++; $display("FAIL pulse_count got=%0d exp=1", Count); end
    checks++; if (Empty !== 1'b0) begin failures++; $display("FAIL pulse_empty got=%b exp=0", Empty); end
    pop_word(got);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL pulse_data got=%h exp=%h", got, exp); end
    checks++; if (Count !== 4'd0 || Empty !== 1'b1 || Data_Out !== 8'h00)
      begin failures++; $display("FAIL pulse_drained count=%0d empty=%b data=%h exp 0/1/00", Count, Empty, Data_Out); end
    Read_En = 1'b1; tick(); Read_En = 1'b0;
    checks++; if (Count !== 4'd0 || Overflow !== 1'b0)
      begin failures++; $display("FAIL empty_read count=%0d ovf=%b exp 0/0", Count, Overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] got, exp;
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    checks++; if (Full !== 1'b1 || Count !== 4'd8)
      begin failures++; $display("FAIL ovf_fill full=%b count=%0d exp 1/8", Full, Count); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", Overflow); end
    push_word(8'hFF);
    checks++; if (Overflow !== 1'b1 || Count !== 4'd8)
      begin failures++; $display("FAIL ovf_set ovf=%b count=%0d exp 1/8", Overflow, Count); end
    for (int i = 0; i < 8; i++) begin
      pop_word(got);
      exp = sb.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, got, exp); end
    end
    checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", Empty); end
  endtask

  task automatic test_full_simul();
    logic [7:0] got, exp;
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    got = Data_Out;
    Data_In = 8'h55; Flag_Rx = 1'b1; Read_En = 1'b1;
    tick();
    Flag_Rx = 1'b0; Read_En = 1'b0;
    exp = sb.pop_front();
    sb.push_back(8'h55);
    checks++; if (got !== exp) begin failures++; $display("FAIL simul_head got=%h exp=%h", got, exp); end
    tick();
    checks++; if (Overflow !== 1'b0 || Count !== 4'd8)
      begin failures++; $display("FAIL simul_full ovf=%b count=%0d exp 0/8", Overflow, Count); end
    for (int i = 0; i < 8; i++) begin
      pop_word(got);
      exp = sb.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got, exp;
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'(8'hC0 + i));
    for (int i = 0; i < 5; i++) begin
      pop_word(got);
      exp = sb.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL wrap_first[%0d] got=%h exp=%h", i, got, exp); end
    end
    for (int i = 0; i < 6; i++) push_word(8'(8'h10 + i));
    checks++; if (Count !== 4'd6) begin failures++; $display("FAIL wrap_count got=%0d exp=6", Count); end
    for (int i = 0; i < 6; i++) begin
      pop_word(got);
      exp = sb.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, got, exp); end
    end
    checks++; if (Empty !== 1'b1 || Data_Out !== 8'h00)
      begin failures++; $display("FAIL wrap_empty empty=%b data=%h exp 1/00", Empty, Data_Out); end
  endtask

  task automatic test_reset_flag_high();
    logic [7:0] got, exp;
    Reset = 1'b1; Data_In = 8'h77; Flag_Rx = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    sb.delete(); m_count = 0;
    tick(); tick();
    checks++; if (Count !== 4'd0) begin failures++; $display("FAIL flaghigh_nowrite count=%0d exp=0", Count); end
    Flag_Rx = 1'b0;
    tick();
    push_word(8'h3C);
    checks++; if (Count !== 4'd1) begin failures++; $display("FAIL flaghigh_count got=%0d exp=1", Count); end
    pop_word(got);
    exp = sb.pop_front();
    checks++; if (got !== exp) begin failures++; $display("FAIL flaghigh_data got=%h exp=%h", got, exp); end
  endtask

  task automatic test_clear_overflow();
    logic [7:0] got, exp;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h80 + i));
    push_word(8'hEE);
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL clr_preset got=%b exp=1", Overflow); end
    Clear_Overflow = 1'b1; tick(); Clear_Overflow = 1'b0;
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL clr_clear got=%b exp=0", Overflow); end
    Data_In = 8'hAA; Flag_Rx = 1'b1; Clear_Overflow = 1'b1;
    tick();
    Flag_Rx = 1'b0; Clear_Overflow = 1'b0;
    tick();
    checks++; if (Overflow !== 1'b1 || Count !== 4'd8)
      begin failures++; $display("FAIL clr_setwins ovf=%b count=%0d exp 1/8", Overflow, Count); end
    for (int i = 0; i < 4; i++) begin
      pop_word(got);
      exp = sb.pop_front();
      checks++; if (got !== exp) begin failures++; $display("FAIL clr_drain[%0d] got=%h exp=%h", i, got, exp); end
    end
    checks++; if (Count !== 4'd4 || Overflow !== 1'b1)
      begin failures++; $display("FAIL clr_mid count=%0d ovf=%b exp 4/1", Count, Overflow); end
    Reset = 1'b1; tick(); Reset = 1'b0;
    checks++; if (Count !== 4'd0 || Empty !== 1'b1 || Overflow !== 1'b0 || Full !== 1'b0 || Data_Out !== 8'h00)
      begin failures++; $display("FAIL midreset count=%0d empty=%b ovf=%b full=%b data=%h exp 0/1/0/0/00",
                                 Count, Empty, Overflow, Full, Data_Out); end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_overflow();
    test_full_simul();
    test_wrap();
    test_reset_flag_high();
    test_clear_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
